// File: rtl/cnn_layer_accel_quad_job_ctrl_pkg.sv
// Shared definitions for the quad job controller: FSM states, descriptor layout,
// datapath widths and the default number of configuration ports.
package cnn_layer_accel_quad_job_ctrl_pkg;

    localparam int unsigned CFG_PORTS_DEF = 4;
    localparam int unsigned PARAM_W       = 128;
    localparam int unsigned CFG_DATA_W    = 128;
    localparam int unsigned DIM_W         = 16;
    localparam int unsigned BEATS_W       = 8;
    localparam int unsigned SEL_W         = 2;
    localparam int unsigned WD_W          = 16;

    // Descriptor field offsets inside job_parameters
    localparam int unsigned ROWS_LSB  = 0;
    localparam int unsigned COLS_LSB  = 16;
    localparam int unsigned DEPTH_LSB = 32;
    localparam int unsigned BEATS_LSB = 48;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ACCEPT    = 3'd1,
        ST_CONFIG    = 3'd2,
        ST_FETCH_REQ = 3'd3,
        ST_RUN       = 3'd4,
        ST_DONE      = 3'd5
    } job_state_e;

endpackage

// File: rtl/cnn_layer_accel_cfg_arb.sv
// Fixed-priority picker for the config ports: lowest-index request wins,
// returns a one-hot grant plus its encoded index.
module cnn_layer_accel_cfg_arb
    import cnn_layer_accel_quad_job_ctrl_pkg::*;
(
    input  logic [3:0]       req,
    output logic [3:0]       grant,
    output logic [SEL_W-1:0] sel
);

    // Scan high to low so the lowest set bit is the last (winning) assignment
    always_comb begin
        grant = '0;
        sel   = '0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) begin
                grant = 4'(1) << i;
                sel   = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/cnn_layer_accel_quad_job_ctrl.sv
// Quad-side job/config handshake responder on the interface clock.
// Optional watchdog: define QUAD_JOB_CTRL_TIMEOUT_EN to abort jobs stuck in
// FETCH_REQ/RUN/DONE after C_TIMEOUT_CYCLES and raise a sticky job_err.
module cnn_layer_accel_quad_job_ctrl
    import cnn_layer_accel_quad_job_ctrl_pkg::*;
#(
    parameter int unsigned C_NUM_CFG_PORTS  = CFG_PORTS_DEF,
    parameter int unsigned C_TIMEOUT_CYCLES = 65535
) (
    input  logic                       clk_if,
    input  logic                       rst,
    input  logic                       job_start,
    input  logic                       job_parameters_valid,
    input  logic [PARAM_W-1:0]         job_parameters,
    output logic                       job_accept,
    input  logic [C_NUM_CFG_PORTS-1:0] config_valid,
    input  logic [CFG_DATA_W-1:0]      config_data,
    output logic [C_NUM_CFG_PORTS-1:0] config_accept,
    output logic                       job_fetch_request,
    input  logic                       job_fetch_ack,
    input  logic                       job_fetch_complete,
    output logic                       job_complete,
    input  logic                       job_complete_ack,
    output logic [DIM_W-1:0]           job_rows,
    output logic [DIM_W-1:0]           job_cols,
    output logic [DIM_W-1:0]           job_depth,
    output logic                       cfg_wr_en,
    output logic [SEL_W-1:0]           cfg_wr_sel,
    output logic [CFG_DATA_W-1:0]      cfg_wr_data,
    output logic                       core_start,
    input  logic                       core_done,
    output logic                       job_busy,
    output logic                       job_err
);

    job_state_e                 state;
    job_state_e                 state_next;
    logic [BEATS_W-1:0]         cfg_cnt;
    logic                       fetch_seen;
    logic                       core_seen;
    logic [C_NUM_CFG_PORTS-1:0] arb_req;
    logic [C_NUM_CFG_PORTS-1:0] arb_grant;
    logic [SEL_W-1:0]           arb_sel;
    logic                       cfg_hs;
    logic                       start_hs;
    logic                       wd_expired;

    // Bits above the descriptor fields carry nothing for this block
    logic unused_params;
    assign unused_params = ^job_parameters[PARAM_W-1:BEATS_LSB+BEATS_W];

    assign start_hs = job_start && job_parameters_valid;
    assign arb_req  = (state == ST_CONFIG) ? config_valid : '0;
    assign cfg_hs   = |arb_grant;

    cnn_layer_accel_cfg_arb u_cfg_arb (
        .req   (arb_req),
        .grant (arb_grant),
        .sel   (arb_sel)
    );

`ifdef QUAD_JOB_CTRL_TIMEOUT_EN
    logic [WD_W-1:0] wd_cnt;
    logic            wd_watch;

    assign wd_watch   = (state == ST_FETCH_REQ) || (state == ST_RUN) || (state == ST_DONE);
    assign wd_expired = wd_watch && (wd_cnt == WD_W'(C_TIMEOUT_CYCLES - 1));

    // Watchdog counts dwell time in the host-waiting states, restarting on every transition
    always_ff @(posedge clk_if or posedge rst) begin
        if (rst) begin
            wd_cnt  <= '0;
            job_err <= 1'b0;
        end else begin
            if (!wd_watch || (state_next != state)) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            if (wd_expired) begin
                job_err <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^WD_W'(C_TIMEOUT_CYCLES);
    assign wd_expired     = 1'b0;
    assign job_err        = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_if or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a watchdog expiry overrides everything and returns to IDLE
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (start_hs) state_next = ST_ACCEPT;
            ST_ACCEPT:    state_next = (cfg_cnt != '0) ? ST_CONFIG : ST_FETCH_REQ;
            ST_CONFIG:    if (cfg_hs && (cfg_cnt == BEATS_W'(1))) state_next = ST_FETCH_REQ;
            ST_FETCH_REQ: if (job_fetch_ack) state_next = ST_RUN;
            ST_RUN:       if ((fetch_seen || job_fetch_complete) && (core_seen || core_done))
                              state_next = ST_DONE;
            ST_DONE:      if (job_complete_ack) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
        if (wd_expired) begin
            state_next = ST_IDLE;
        end
    end

    // Handshake outputs decoded from the registered state
    always_comb begin
        job_accept        = 1'b0;
        job_fetch_request = 1'b0;
        job_complete      = 1'b0;
        job_busy          = (state != ST_IDLE);
        config_accept     = arb_grant;
        case (state)
            ST_ACCEPT:    job_accept        = 1'b1;
            ST_FETCH_REQ: job_fetch_request = 1'b1;
            ST_DONE:      job_complete      = 1'b1;
            default:      ;
        endcase
    end

    // Descriptor capture, beat counter, config write port and core start pulse
    always_ff @(posedge clk_if or posedge rst) begin
        if (rst) begin
            job_rows    <= '0;
            job_cols    <= '0;
            job_depth   <= '0;
            cfg_cnt     <= '0;
            cfg_wr_en   <= 1'b0;
            cfg_wr_sel  <= '0;
            cfg_wr_data <= '0;
            core_start  <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && start_hs) begin
                job_rows  <= job_parameters[ROWS_LSB  +: DIM_W];
                job_cols  <= job_parameters[COLS_LSB  +: DIM_W];
                job_depth <= job_parameters[DEPTH_LSB +: DIM_W];
                cfg_cnt   <= job_parameters[BEATS_LSB +: BEATS_W];
            end else if (cfg_hs) begin
                cfg_cnt <= cfg_cnt - BEATS_W'(1);
            end
            cfg_wr_en <= cfg_hs;
            if (cfg_hs) begin
                cfg_wr_sel  <= arb_sel;
                cfg_wr_data <= config_data;
            end
            core_start <= (state == ST_FETCH_REQ) && (state_next == ST_RUN);
        end
    end

    // Completion-event latches, live only while RUN persists
    always_ff @(posedge clk_if or posedge rst) begin
        if (rst) begin
            fetch_seen <= 1'b0;
            core_seen  <= 1'b0;
        end else if ((state == ST_RUN) && (state_next == ST_RUN)) begin
            fetch_seen <= fetch_seen || job_fetch_complete;
            core_seen  <= core_seen  || core_done;
        end else begin
            fetch_seen <= 1'b0;
            core_seen  <= 1'b0;
        end
    end

endmodule
